// File: rtl/taylor_trig_pkg.sv
// ============================================================================
// Module      : taylor_trig_pkg
// Description : Shared types, mode constants and coefficient helper for the
//               taylor_trig sine/cosine engine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package taylor_trig_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_SQUARE   = 3'd1,
        S_MUL_X2   = 3'd2,
        S_MUL_COEF = 3'd3,
        S_ACC      = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic MODE_COS = 1'b0;
    localparam logic MODE_SIN = 1'b1;

    // floor(2^cw / denom): cos uses (2k-1)(2k), sin uses (2k)(2k+1); k<1 gives 0
    function automatic logic [31:0] coef_value(input logic mode, input int k, input int cw);
        longint denom;
        longint one;
        if (k < 1) begin
            return '0;
        end
        if (mode == MODE_SIN) begin
            denom = longint'(2 * k) * longint'(2 * k + 1);
        end else begin
            denom = longint'(2 * k - 1) * longint'(2 * k);
        end
        one = longint'(1) << cw;
        return 32'(one / denom);
    endfunction

endpackage

`default_nettype wire

// File: rtl/taylor_trig_if.sv
// ============================================================================
// Module      : taylor_trig_if
// Description : Start/ready/done request and result bundle for taylor_trig.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface taylor_trig_if #(
    parameter int W     = 10,
    parameter int TERMS = 8
);
    localparam int NW = $clog2(TERMS + 1);

    logic          start;
    logic          mode;
    logic [NW-1:0] n_terms;
    logic [W-1:0]  x;
    logic          ready;
    logic          done;
    logic [W-1:0]  result;
    logic [NW-1:0] terms_used;

    modport master (
        output start, mode, n_terms, x,
        input  ready, done, result, terms_used
    );

    modport slave (
        input  start, mode, n_terms, x,
        output ready, done, result, terms_used
    );
endinterface

`default_nettype wire

// File: rtl/taylor_coef_rom.sv
// ============================================================================
// Module      : taylor_coef_rom
// Description : Combinational (mode, k) -> reciprocal Taylor coefficient table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module taylor_coef_rom
    import taylor_trig_pkg::*;
#(
    parameter int TERMS = 8,
    parameter int CW    = 16,
    localparam int KW   = $clog2(TERMS + 1)
) (
    input  wire logic          mode,
    input  wire logic [KW-1:0] k,
    output logic      [CW-1:0] coef
);

    localparam int DEPTH = 2 ** KW;

    logic [CW-1:0] w_cos_tab [DEPTH];
    logic [CW-1:0] w_sin_tab [DEPTH];

    // Table covers the full index range so k never needs a bounds check; k=0
    // and k>=TERMS read as zero.
    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_tab
            if (i < TERMS) begin : g_used
                assign w_cos_tab[i] = CW'(coef_value(MODE_COS, i, CW));
                assign w_sin_tab[i] = CW'(coef_value(MODE_SIN, i, CW));
            end else begin : g_unused
                assign w_cos_tab[i] = '0;
                assign w_sin_tab[i] = '0;
            end
        end
    endgenerate

    always_comb begin
        coef = (mode == MODE_SIN) ? w_sin_tab[k] : w_cos_tab[k];
    end

endmodule

`default_nettype wire

// File: rtl/taylor_trig.sv
// ============================================================================
// Module      : taylor_trig
// Description : Multi-cycle truncated-Taylor sine/cosine engine with early
//               stop on term underflow; FSM controller plus datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module taylor_trig
    import taylor_trig_pkg::*;
#(
    parameter int W     = 10,
    parameter int GUARD = 4,
    parameter int TERMS = 8,
    parameter int CW    = 16
) (
    input  wire logic clk,
    input  wire logic rst,
    taylor_trig_if.slave bus
);

    localparam int IF  = W + GUARD;
    localparam int NW  = $clog2(TERMS + 1);
    localparam int AW  = IF + 3;
    localparam int PW  = 2 * (IF + 1);
    localparam int CPW = IF + 1 + CW;

    state_t          r_state;
    state_t          w_next;
    logic [W-1:0]    r_x;
    logic            r_mode;
    logic [NW-1:0]   r_n;
    logic [NW-1:0]   r_k;
    logic [IF:0]     r_x2;
    logic [IF:0]     r_tmp;
    logic signed [AW-1:0] r_acc;
    logic [W-1:0]    r_result;
    logic [NW-1:0]   r_terms;

    logic [IF:0]     w_x_ext;
    logic [PW-1:0]   w_sq_prod;
    logic [IF:0]     w_x2;
    logic [IF:0]     w_tmp0;
    logic [PW-1:0]   w_mx_prod;
    logic [IF:0]     w_tmp_x2;
    logic [CW-1:0]   w_coef;
    logic [CPW-1:0]  w_cf_prod;
    logic [IF:0]     w_tmp_cf;
    logic [NW-1:0]   w_k_inc;
    logic [NW-1:0]   w_n_clamped;
    logic signed [AW-1:0] w_tmp_s;
    logic signed [AW-1:0] w_acc_next;
    logic signed [AW-1:0] w_res_shift;
    logic [AW-1:0]   w_res_u;
    logic [W-1:0]    w_res_sat;

    taylor_coef_rom #(
        .TERMS (TERMS),
        .CW    (CW)
    ) u_rom (
        .mode (r_mode),
        .k    (r_k),
        .coef (w_coef)
    );

    // Datapath arithmetic: unsigned Q1.IF operands, every product floored
    always_comb begin
        w_x_ext    = {1'b0, r_x, {GUARD{1'b0}}};
        w_sq_prod  = PW'(w_x_ext) * PW'(w_x_ext);
        w_x2       = (IF + 1)'(w_sq_prod >> IF);
        w_tmp0     = (r_mode == MODE_SIN) ? w_x_ext : ((IF + 1)'(1) << IF);
        w_mx_prod  = PW'(r_tmp) * PW'(r_x2);
        w_tmp_x2   = (IF + 1)'(w_mx_prod >> IF);
        w_cf_prod  = CPW'(r_tmp) * CPW'(w_coef);
        w_tmp_cf   = (IF + 1)'(w_cf_prod >> CW);
        w_k_inc    = r_k + NW'(1);
        w_tmp_s    = $signed({{(AW - IF - 1){1'b0}}, r_tmp});
        w_acc_next = r_k[0] ? (r_acc - w_tmp_s) : (r_acc + w_tmp_s);
    end

    always_comb begin
        w_n_clamped = bus.n_terms;
        if (bus.n_terms == '0) begin
            w_n_clamped = NW'(1);
        end else if (bus.n_terms > NW'(TERMS)) begin
            w_n_clamped = NW'(TERMS);
        end
    end

    // Drop GUARD+1 fraction bits, then clamp into [0, 2^W-1]
    always_comb begin
        w_res_shift = r_acc >>> (GUARD + 1);
        w_res_u     = w_res_shift;
        if (r_acc < 0) begin
            w_res_sat = '0;
        end else if (|w_res_u[AW-1:W]) begin
            w_res_sat = '1;
        end else begin
            w_res_sat = w_res_u[W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (bus.start) w_next = S_SQUARE;
            S_SQUARE:   w_next = (r_n == NW'(1)) ? S_DONE : S_MUL_X2;
            S_MUL_X2:   w_next = S_MUL_COEF;
            S_MUL_COEF: w_next = (w_tmp_cf == '0) ? S_DONE : S_ACC;
            S_ACC:      w_next = (w_k_inc == r_n) ? S_DONE : S_MUL_X2;
            S_DONE:     w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    // Result is presented combinationally during DONE so it is valid with the pulse
    always_comb begin
        bus.ready      = (r_state == S_IDLE);
        bus.done       = (r_state == S_DONE);
        bus.result     = (r_state == S_DONE) ? w_res_sat : r_result;
        bus.terms_used = (r_state == S_DONE) ? r_k : r_terms;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x      <= '0;
            r_mode   <= MODE_COS;
            r_n      <= '0;
            r_k      <= '0;
            r_x2     <= '0;
            r_tmp    <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_terms  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_x    <= bus.x;
                        r_mode <= bus.mode;
                        r_n    <= w_n_clamped;
                    end
                end
                S_SQUARE: begin
                    r_x2  <= w_x2;
                    r_tmp <= w_tmp0;
                    r_acc <= $signed({{(AW - IF - 1){1'b0}}, w_tmp0});
                    r_k   <= NW'(1);
                end
                S_MUL_X2:   r_tmp <= w_tmp_x2;
                S_MUL_COEF: r_tmp <= w_tmp_cf;
                S_ACC: begin
                    r_acc <= w_acc_next;
                    r_k   <= w_k_inc;
                end
                S_DONE: begin
                    r_result <= w_res_sat;
                    r_terms  <= r_k;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_taylor_trig.sv
// ============================================================================
// Module      : tb_taylor_trig
// Description : Directed vector bench for taylor_trig (W=10, GUARD=4, TERMS=8).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_taylor_trig;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    taylor_trig_if #(.W(10), .TERMS(8)) bus ();

    taylor_trig #(
        .W     (10),
        .GUARD (4),
        .TERMS (8),
        .CW    (16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      name;
        logic       mode;
        logic [3:0] n;
        logic [9:0] x;
        int         exp_res;
        int         tol;
        int         exp_terms;
        int         exp_cyc;
    } vec_t;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_tol(input string name, input int act, input int exp, input int tol);
        int d;
        total++;
        d = act - exp;
        if (d < 0) d = -d;
        if (d > tol) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d +/-%0d", name, act, exp, tol);
        end
    endtask

    // Called at posedge+1. Cycle 1 is the interval right after the accepting edge.
    task automatic run_vec(input vec_t v, input bit hold_start);
        int cyc;
        int res;
        int tu;
        int readies;
        bus.start   = 1'b1;
        bus.mode    = v.mode;
        bus.n_terms = v.n;
        bus.x       = v.x;
        @(posedge clk); #1;
        if (!hold_start) bus.start = 1'b0;
        cyc = 1;
        readies = 0;
        while (!bus.done && cyc < 60) begin
            if (bus.ready) readies++;
            @(posedge clk); #1;
            cyc++;
        end
        res = int'(bus.result);
        tu  = int'(bus.terms_used);
        check({v.name, " ready_in_run"}, readies, 0);
        check({v.name, " done_cycle"}, cyc, v.exp_cyc);
        check_tol({v.name, " result"}, res, v.exp_res, v.tol);
        check({v.name, " terms_used"}, tu, v.exp_terms);
        check({v.name, " ready_with_done"}, int'(bus.ready), 0);
        bus.start = 1'b0;
        @(posedge clk); #1;
        check({v.name, " done_pulse"}, int'(bus.done), 0);
        check({v.name, " ready_after"}, int'(bus.ready), 1);
        check({v.name, " result_held"}, int'(bus.result), res);
    endtask

    vec_t vecs [8];

    initial begin
        int extra_done;
        int held;

        // Hand-derived with Q1.14 floor arithmetic and Q0.16 floor coefficients.
        // cos(0.5): 16384-2048+42, term k=3 floors to 0 -> stop at cycle 10.
        vecs[0] = '{"cos_n8_x05",   1'b0, 4'd8,  10'd512,  449, 2, 3, 10};
        // sin(0.5): 8192-341+4, term k=3 floors to 0.
        vecs[1] = '{"sin_n8_x05",   1'b1, 4'd8,  10'd512,  245, 2, 3, 10};
        vecs[2] = '{"sin_n1_x05",   1'b1, 4'd1,  10'd512,  256, 0, 1, 2};
        vecs[3] = '{"cos_n2_x05",   1'b0, 4'd2,  10'd512,  448, 0, 2, 5};
        vecs[4] = '{"cos_n8_x0",    1'b0, 4'd8,  10'd0,    512, 0, 1, 4};
        // n=15 clamps to 8; 16384-8176+679-22, k=4 term floors to 0.
        vecs[5] = '{"cos_n15_xmax", 1'b0, 4'd15, 10'd1023, 277, 2, 4, 13};
        vecs[6] = '{"cos_n0_x05",   1'b0, 4'd0,  10'd512,  512, 0, 1, 2};
        // 16368-2722 = 13646 -> 426
        vecs[7] = '{"sin_n2_xmax",  1'b1, 4'd2,  10'd1023, 426, 0, 2, 5};

        bus.start   = 1'b0;
        bus.mode    = 1'b0;
        bus.n_terms = '0;
        bus.x       = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ready",  int'(bus.ready), 1);
        check("reset_done",   int'(bus.done), 0);
        check("reset_result", int'(bus.result), 0);
        check("reset_terms",  int'(bus.terms_used), 0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], 1'b0);
            @(posedge clk); #1;
        end

        // start held through the entire operation must be taken only once
        run_vec(vecs[3], 1'b1);
        extra_done = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus.done || !bus.ready) extra_done++;
            @(posedge clk); #1;
        end
        check("hold_start_single_accept", extra_done, 0);

        // Reset while in MUL_COEF (cycle 3 of a long run)
        held = int'(bus.result);
        bus.start   = 1'b1;
        bus.mode    = 1'b0;
        bus.n_terms = 4'd8;
        bus.x       = 10'd1023;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_reset_busy", int'(bus.ready), 0);
        check("pre_reset_result_held", int'(bus.result), held);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_ready",  int'(bus.ready), 1);
        check("midrst_result", int'(bus.result), 0);
        check("midrst_terms",  int'(bus.terms_used), 0);
        check("midrst_done",   int'(bus.done), 0);
        extra_done = 0;
        for (int i = 0; i < 30; i++) begin
            @(posedge clk); #1;
            if (bus.done) extra_done++;
        end
        check("midrst_no_done", extra_done, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
